regfile_write_arbiter: RTL and testbench

//   Shares the single write port (W_Adr/we/W) of the 8x16 Register_File among

---
 rtl/rf_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/regfile_write_arbiter.sv | 75 +++++++
 tb/tb_regfile_write_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-command record.
// No logic lives here; widths only.
// Used by the write arbiter and anything that drives the RF write port.
package rf_pkg;

    localparam int RF_AW    = 3;
    localparam int RF_DW    = 16;
    localparam int RF_NREGS = 8;
    localparam int NREQ_MAX = 8;

    // One register-file write: target address and data.
    typedef struct packed {
        logic [RF_AW-1:0] adr;
        logic [RF_DW-1:0] data;
    } rf_wr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant among NREQ requesters, search starts at ptr.
// Latency: purely combinational, zero cycles.
// Backpressure: a requester not granted simply sees no grant bit and waits.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            gnt_vld,
    output logic [PW-1:0]   gnt_idx,
    output logic [PW-1:0]   ptr_next
);

    int   idx;
    logic found;

    // Walk from ptr upward with wrap; the first valid index wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = PW'(idx);
            end
        end
    end

    assign gnt_vld = found;

    // Next search starts just past the winner, wrapping at NREQ.
    assign ptr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single RF write port among NREQ requesters, round-robin.
// Latency: grant in cycle N, we/W_Adr/W registered and valid during N+1.
// Backpressure: req_ready withheld while hold=1, during reset, or while another requester wins.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_adr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [AW-1:0]    W_Adr,
    output logic             we,
    output logic [DW-1:0]    W,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   ptr_next;
    logic [PW-1:0]   gnt_idx;
    logic            gnt_vld;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] arb_valid;
    logic [AW-1:0]   sel_adr;
    logic [DW-1:0]   sel_data;

    // hold blocks only new grants; an already registered write still goes out.
    assign arb_valid = hold ? '0 : req_valid;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .valid    (arb_valid),
        .ptr      (rr_ptr),
        .grant    (grant),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx),
        .ptr_next (ptr_next)
    );

    // No handshake may complete while reset is asserted.
    assign req_ready = reset ? '0 : grant;

    assign sel_adr  = req_adr[int'(gnt_idx)*AW +: AW];
    assign sel_data = req_data[int'(gnt_idx)*DW +: DW];

    // Register the winning write and advance the round-robin pointer past it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            we     <= 1'b0;
            W_Adr  <= '0;
            W      <= '0;
        end else begin
            we <= gnt_vld;
            if (gnt_vld) begin
                rr_ptr <= ptr_next;
                W_Adr  <= sel_adr;
                W      <= sel_data;
            end
        end
    end

    assign busy = we;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: arbiter driving a behavioural 8x16 register file.
// Expected writes are queued when a grant is expected and popped when we is seen.
// Read-back goes through a single combinational read port on the RF model.
module tb_regfile_write_arbiter;
    import rf_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = RF_AW;
    localparam int DW   = RF_DW;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               hold = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*AW-1:0] req_adr = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic [AW-1:0]      W_Adr;
    logic               we;
    logic [DW-1:0]      W;
    logic               busy;

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_adr   (req_adr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .W_Adr     (W_Adr),
        .we        (we),
        .W         (W),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register file model: async clear, write on rising edge, one read port R.
    logic [DW-1:0] rf_mem [RF_NREGS];
    logic [AW-1:0] r_adr = '0;
    logic [DW-1:0] r_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RF_NREGS; i++) rf_mem[i] <= '0;
        end else if (we) begin
            rf_mem[W_Adr] <= W;
        end
    end

    assign r_out = rf_mem[r_adr];

    int     n_checks = 0;
    int     n_pass   = 0;
    rf_wr_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_adr[i*AW +: AW]   = a;
        req_data[i*DW +: DW]  = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
    endtask

    // One clock: check the write side against the scoreboard, check the grant,
    // queue any expected write, then step to just after the next rising edge.
    task automatic cyc(input string tag, input logic [NREQ-1:0] exp_rdy);
        logic   exp_we;
        rf_wr_t e;
        @(negedge clk);
        exp_we = (exp_q.size() > 0);
        chk({tag, ".we"},   32'(we),   32'(exp_we));
        chk({tag, ".busy"}, 32'(busy), 32'(exp_we));
        if (exp_we) begin
            e = exp_q.pop_front();
            chk({tag, ".W_Adr"}, 32'(W_Adr), 32'(e.adr));
            chk({tag, ".W"},     32'(W),     32'(e.data));
        end
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        for (int g = 0; g < NREQ; g++) begin
            if (exp_rdy[g]) exp_q.push_back('{adr: req_adr[g*AW +: AW], data: req_data[g*DW +: DW]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        r_adr = a;
        #1;
        chk(tag, 32'(r_out), 32'(exp));
    endtask

    localparam logic [NREQ-1:0] RR_SEQ [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        // 1. Reset, then idle.
        reset = 1'b1;
        set_req(1, 1'b1, 3'd1, 16'h0101);
        #1;
        chk("rst.ready_gated", 32'(req_ready), 32'(0));
        chk("rst.we",          32'(we),        32'(0));
        chk("rst.W_Adr",       32'(W_Adr),     32'(0));
        chk("rst.W",           32'(W),         32'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_reqs();
        for (int i = 0; i < 5; i++) cyc("idle", 4'b0000);

        // 2. Single requester 2.
        set_req(2, 1'b1, 3'd5, 16'hA5A5);
        cyc("single.grant", 4'b0100);
        clear_reqs();
        cyc("single.write", 4'b0000);
        cyc("single.idle", 4'b0000);
        chk("single.hold_adr", 32'(W_Adr), 32'(5));
        chk("single.hold_W",   32'(W),     32'(16'hA5A5));
        rd("single.rf5", 3'd5, 16'hA5A5);

        // Bring rr_ptr from 3 to 0 with a lone req 3.
        set_req(3, 1'b1, 3'd7, 16'h0777);
        cyc("ptr0.grant", 4'b1000);
        clear_reqs();

        // 3. All four continuously valid; each granted requester presents fresh data.
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), {8'(s + 8'h10), 8'(i)});
            cyc("rr", RR_SEQ[s]);
        end
        clear_reqs();
        cyc("rr.drain", 4'b0000);
        rd("rr.rf2", 3'd2, 16'h1202);
        rd("rr.rf0", 3'd0, 16'h1400);

        // rr_ptr is 1; a lone req 3 brings it back to 0.
        set_req(3, 1'b1, 3'd7, 16'h0777);
        cyc("ptr0b.grant", 4'b1000);
        clear_reqs();

        // 4. Two writes to the same address, issued in grant order.
        set_req(0, 1'b1, 3'd3, 16'h1111);
        set_req(1, 1'b1, 3'd3, 16'h2222);
        cyc("same.g0", 4'b0001);
        set_req(0, 1'b0, '0, '0);
        cyc("same.g1", 4'b0010);
        clear_reqs();
        cyc("same.w1", 4'b0000);
        cyc("same.idle", 4'b0000);
        rd("same.rf3", 3'd3, 16'h2222);

        // 5. hold: write in flight completes, new grants are blocked.
        set_req(1, 1'b1, 3'd4, 16'h4444);
        set_req(2, 1'b1, 3'd2, 16'hBEEF);
        cyc("hold.pre", 4'b0100);
        set_req(2, 1'b0, '0, '0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) cyc("hold.on", 4'b0000);
        hold = 1'b0;
        cyc("hold.rel", 4'b0010);
        clear_reqs();
        cyc("hold.drain", 4'b0000);
        cyc("hold.idle", 4'b0000);
        rd("hold.rf2", 3'd2, 16'hBEEF);
        rd("hold.rf4", 3'd4, 16'h4444);

        // 6. Reset with a write in flight.
        set_req(2, 1'b1, 3'd6, 16'hFFFF);
        cyc("rstmid.grant", 4'b0100);
        chk("rstmid.we_pre", 32'(we), 32'(1));
        reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rstmid.we",    32'(we),        32'(0));
        chk("rstmid.busy",  32'(busy),      32'(0));
        chk("rstmid.ready", 32'(req_ready), 32'(0));
        rd("rstmid.rf3_cleared", 3'd3, 16'h0000);
        rd("rstmid.rf6", 3'd6, 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), 16'hC000 | 16'(i));
        cyc("rstmid.restart", 4'b0001);
        clear_reqs();
        cyc("rstmid.drain", 4'b0000);
        cyc("rstmid.idle", 4'b0000);
        rd("rstmid.rf0", 3'd0, 16'hC000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
